// File: rtl/naive_bus_pkg.sv
// Shared naive-bus widths, types and the address-window decode helper.
package naive_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [BE_W-1:0]   be_t;

  // An address falls inside a window when every non-offset bit equals the base.
  function automatic logic addr_hit(input addr_t a, input addr_t base, input addr_t mask);
    return ((a & ~mask) == base);
  endfunction

endpackage

// File: rtl/naive_arbiter.sv
// One-hot request arbiter; NAIVE_ROUTER_RR_EN selects round-robin, otherwise lowest index wins.
module naive_arbiter
#(
  parameter int N = 2
)(
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] i_req,
  input  logic         i_adv,
  output logic [N-1:0] o_gnt
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] w_ptr;
  logic [IDX_W-1:0] w_win;
  logic [2*N-1:0]   w_dbl_req;
  logic [2*N-1:0]   w_dbl_gnt;
  logic [N-1:0]     w_rot_req;
  logic [N-1:0]     w_rot_gnt;

  // Rotate so w_ptr sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    w_dbl_req = {i_req, i_req} >> w_ptr;
    w_rot_req = w_dbl_req[N-1:0];
    w_rot_gnt = w_rot_req & (~w_rot_req + N'(1));
    w_dbl_gnt = {w_rot_gnt, w_rot_gnt} << w_ptr;
    o_gnt     = w_dbl_gnt[2*N-1:N];
  end

  // Encode the one-hot grant back to an index.
  always_comb begin
    w_win = '0;
    for (int k = 0; k < N; k++) begin
      w_win = w_win | (IDX_W'(k) & {IDX_W{o_gnt[k]}});
    end
  end

`ifdef NAIVE_ROUTER_RR_EN
  logic [IDX_W-1:0] r_ptr;

  // Pointer moves just past the master that was actually granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (i_adv && (|i_req)) begin
      r_ptr <= (w_win == IDX_W'(N - 1)) ? '0 : (w_win + IDX_W'(1));
    end
  end

  assign w_ptr = r_ptr;
`else
  logic w_unused;

  assign w_ptr    = '0;
  assign w_unused = ^{clk, rstn, i_adv, w_win};
`endif

endmodule

// File: rtl/naive_router.sv
// N-master x N-slave naive-bus crossbar: combinational decode/arbitration, registered read return.
// Optional macro NAIVE_ROUTER_RR_EN switches per-slave arbitration from fixed priority to round-robin.
module naive_router
  import naive_bus_pkg::*;
#(
  parameter int                  N_MASTER    = 2,
  parameter int                  N_SLAVE     = 1,
  parameter addr_t [N_SLAVE-1:0] SLAVES_MASK = {32'h0000_ffff},
  parameter addr_t [N_SLAVE-1:0] SLAVES_BASE = {32'h0000_0000}
)(
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_MASTER-1:0] m_rd_req,
  output logic [N_MASTER-1:0] m_rd_gnt,
  input  addr_t               m_rd_addr [N_MASTER],
  output data_t               m_rd_data [N_MASTER],
  input  logic [N_MASTER-1:0] m_wr_req,
  output logic [N_MASTER-1:0] m_wr_gnt,
  input  addr_t               m_wr_addr [N_MASTER],
  input  data_t               m_wr_data [N_MASTER],
  input  be_t                 m_wr_be   [N_MASTER],
  output logic [N_SLAVE-1:0]  s_rd_req,
  output addr_t               s_rd_addr [N_SLAVE],
  input  logic [N_SLAVE-1:0]  s_rd_gnt,
  input  data_t               s_rd_data [N_SLAVE],
  output logic [N_SLAVE-1:0]  s_wr_req,
  output addr_t               s_wr_addr [N_SLAVE],
  output data_t               s_wr_data [N_SLAVE],
  output be_t                 s_wr_be   [N_SLAVE],
  input  logic [N_SLAVE-1:0]  s_wr_gnt
);

  localparam int SIDX_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

  // Returns {hit, slave index}; the lowest-numbered matching window wins.
  function automatic logic [SIDX_W:0] decode(input addr_t a);
    logic              hit;
    logic              take;
    logic [SIDX_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int j = 0; j < N_SLAVE; j++) begin
      take = addr_hit(a, SLAVES_BASE[j], SLAVES_MASK[j]) & ~hit;
      idx  = idx | (SIDX_W'(j) & {SIDX_W{take}});
      hit  = hit | take;
    end
    return {hit, idx};
  endfunction

  logic [N_MASTER-1:0]                          w_rd_hit;
  logic [N_MASTER-1:0]                          w_wr_hit;
  logic [N_MASTER-1:0][SIDX_W-1:0]              w_rd_sidx;
  logic [N_MASTER-1:0][SIDX_W-1:0]              w_wr_sidx;
  logic [N_SLAVE-1:0][N_MASTER-1:0]             w_rd_sreq;
  logic [N_SLAVE-1:0][N_MASTER-1:0]             w_wr_sreq;
  logic [N_SLAVE-1:0][N_MASTER-1:0]             w_rd_sgnt;
  logic [N_SLAVE-1:0][N_MASTER-1:0]             w_wr_sgnt;
  logic [N_MASTER-1:0]                          r_rd_valid;
  logic [N_MASTER-1:0]                          r_rd_unmapped;
  logic [N_MASTER-1:0][SIDX_W-1:0]              r_rd_sidx;

  // Address decode per master, both channels.
  always_comb begin
    for (int m = 0; m < N_MASTER; m++) begin
      {w_rd_hit[m], w_rd_sidx[m]} = decode(m_rd_addr[m]);
      {w_wr_hit[m], w_wr_sidx[m]} = decode(m_wr_addr[m]);
    end
  end

  // Request matrix: which masters compete for which slave.
  always_comb begin
    for (int j = 0; j < N_SLAVE; j++) begin
      for (int m = 0; m < N_MASTER; m++) begin
        w_rd_sreq[j][m] = m_rd_req[m] & w_rd_hit[m] & (w_rd_sidx[m] == SIDX_W'(j));
        w_wr_sreq[j][m] = m_wr_req[m] & w_wr_hit[m] & (w_wr_sidx[m] == SIDX_W'(j));
      end
    end
  end

  for (genvar j = 0; j < N_SLAVE; j++) begin : g_arb
    naive_arbiter #(.N(N_MASTER)) u_rd_arb (
      .clk   (clk),
      .rstn  (rstn),
      .i_req (w_rd_sreq[j]),
      .i_adv (s_rd_gnt[j] & rstn),
      .o_gnt (w_rd_sgnt[j])
    );
    naive_arbiter #(.N(N_MASTER)) u_wr_arb (
      .clk   (clk),
      .rstn  (rstn),
      .i_req (w_wr_sreq[j]),
      .i_adv (s_wr_gnt[j] & rstn),
      .o_gnt (w_wr_sgnt[j])
    );
  end

  // Slave-side AND-OR mux of the picked master; idle slaves see all zeros.
  always_comb begin
    for (int j = 0; j < N_SLAVE; j++) begin
      s_rd_req[j]  = |w_rd_sreq[j];
      s_wr_req[j]  = |w_wr_sreq[j];
      s_rd_addr[j] = '0;
      s_wr_addr[j] = '0;
      s_wr_data[j] = '0;
      s_wr_be[j]   = '0;
      for (int m = 0; m < N_MASTER; m++) begin
        s_rd_addr[j] = s_rd_addr[j] | (m_rd_addr[m] & {ADDR_W{w_rd_sgnt[j][m]}});
        s_wr_addr[j] = s_wr_addr[j] | (m_wr_addr[m] & {ADDR_W{w_wr_sgnt[j][m]}});
        s_wr_data[j] = s_wr_data[j] | (m_wr_data[m] & {DATA_W{w_wr_sgnt[j][m]}});
        s_wr_be[j]   = s_wr_be[j]   | (m_wr_be[m]   & {BE_W{w_wr_sgnt[j][m]}});
      end
    end
  end

  // Master grants (unmapped accesses complete at once) and read-data return.
  always_comb begin
    for (int m = 0; m < N_MASTER; m++) begin
      m_rd_gnt[m]  = rstn & m_rd_req[m] &
                     (~w_rd_hit[m] | (w_rd_sgnt[w_rd_sidx[m]][m] & s_rd_gnt[w_rd_sidx[m]]));
      m_wr_gnt[m]  = rstn & m_wr_req[m] &
                     (~w_wr_hit[m] | (w_wr_sgnt[w_wr_sidx[m]][m] & s_wr_gnt[w_wr_sidx[m]]));
      m_rd_data[m] = (r_rd_valid[m] & ~r_rd_unmapped[m]) ? s_rd_data[r_rd_sidx[m]] : '0;
    end
  end

  // Remember where each granted read went so its data can be steered back next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_valid    <= '0;
      r_rd_unmapped <= '0;
      r_rd_sidx     <= '0;
    end else begin
      r_rd_valid    <= m_rd_gnt;
      r_rd_unmapped <= ~w_rd_hit;
      r_rd_sidx     <= w_rd_sidx;
    end
  end

endmodule

// File: tb/tb_naive_router.sv
// Bench for naive_router (2 masters, 2 slaves): directed scenarios then random traffic vs a reference model.
module tb_naive_router;
  import naive_bus_pkg::*;

  localparam int    NM = 2;
  localparam int    NS = 2;
  localparam addr_t BASE [NS] = '{32'h0000_0000, 32'h0002_0000};
  localparam addr_t MASK [NS] = '{32'h0000_ffff, 32'h0000_ffff};

  logic            clk = 1'b0;
  logic            rstn;
  logic [NM-1:0]   m_rd_req, m_rd_gnt, m_wr_req, m_wr_gnt;
  addr_t           m_rd_addr [NM];
  data_t           m_rd_data [NM];
  addr_t           m_wr_addr [NM];
  data_t           m_wr_data [NM];
  be_t             m_wr_be   [NM];
  logic [NS-1:0]   s_rd_req, s_rd_gnt, s_wr_req, s_wr_gnt;
  addr_t           s_rd_addr [NS];
  data_t           s_rd_data [NS];
  addr_t           s_wr_addr [NS];
  data_t           s_wr_data [NS];
  be_t             s_wr_be   [NS];

  data_t           smem [NS][256];
  data_t           rmem [NS][256];
  int              ptr_rd [NS];
  int              ptr_wr [NS];
  logic [NM-1:0]   exp_rv;
  data_t           exp_rdata [NM];
  logic [NM-1:0]   last_rd_gnt, last_wr_gnt;
  int              n_tests, n_fail;

  naive_router #(
    .N_MASTER    (NM),
    .N_SLAVE     (NS),
    .SLAVES_MASK ({32'h0000_ffff, 32'h0000_ffff}),
    .SLAVES_BASE ({32'h0002_0000, 32'h0000_0000})
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m_rd_req  (m_rd_req),
    .m_rd_gnt  (m_rd_gnt),
    .m_rd_addr (m_rd_addr),
    .m_rd_data (m_rd_data),
    .m_wr_req  (m_wr_req),
    .m_wr_gnt  (m_wr_gnt),
    .m_wr_addr (m_wr_addr),
    .m_wr_data (m_wr_data),
    .m_wr_be   (m_wr_be),
    .s_rd_req  (s_rd_req),
    .s_rd_addr (s_rd_addr),
    .s_rd_gnt  (s_rd_gnt),
    .s_rd_data (s_rd_data),
    .s_wr_req  (s_wr_req),
    .s_wr_addr (s_wr_addr),
    .s_wr_data (s_wr_data),
    .s_wr_be   (s_wr_be),
    .s_wr_gnt  (s_wr_gnt)
  );

  initial forever #5 clk = ~clk;

  function automatic data_t pat(input int j, input int i);
    return 32'hC0DE_0000 | data_t'(j << 12) | data_t'(i);
  endfunction

  // Slave memories: 1-cycle read latency, garbage on the data bus when no read was granted.
  always @(posedge clk) begin
    for (int j = 0; j < NS; j++) begin
      if (!rstn) begin
        for (int i = 0; i < 256; i++) smem[j][i] <= pat(j, i);
        s_rd_data[j] <= $urandom();
      end else begin
        if (s_rd_req[j] && s_rd_gnt[j]) s_rd_data[j] <= smem[j][s_rd_addr[j][9:2]];
        else s_rd_data[j] <= $urandom();
        if (s_wr_req[j] && s_wr_gnt[j])
          for (int b = 0; b < 4; b++)
            if (s_wr_be[j][b]) smem[j][s_wr_addr[j][9:2]][8*b +: 8] <= s_wr_data[j][8*b +: 8];
      end
    end
  end

  function automatic int dec(input addr_t a);
    for (int j = 0; j < NS; j++) if ((a & ~MASK[j]) == BASE[j]) return j;
    return -1;
  endfunction

  function automatic int pick(input logic [NM-1:0] cand, input int start);
    for (int k = 0; k < NM; k++) if (cand[(start + k) % NM]) return (start + k) % NM;
    return -1;
  endfunction

  function automatic addr_t rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return addr_t'($urandom_range(0, 15)) << 2;
    if (r < 9) return 32'h0002_0000 | (addr_t'($urandom_range(0, 15)) << 2);
    return 32'h0001_0000 | (addr_t'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int            srd [NM];
    int            swr [NM];
    int            wrd [NS];
    int            wwr [NS];
    logic [NM-1:0] c_rd, c_wr, e_rg, e_wg, nv;
    logic [NS-1:0] e_srq, e_swq;
    data_t         nd [NM];
    addr_t         ea, ewa;
    data_t         ewd;
    be_t           ebe;
    for (int m = 0; m < NM; m++) begin
      srd[m] = dec(m_rd_addr[m]);
      swr[m] = dec(m_wr_addr[m]);
    end
    for (int j = 0; j < NS; j++) begin
      for (int m = 0; m < NM; m++) begin
        c_rd[m] = m_rd_req[m] && (srd[m] == j);
        c_wr[m] = m_wr_req[m] && (swr[m] == j);
      end
      wrd[j] = pick(c_rd, ptr_rd[j]);
      wwr[j] = pick(c_wr, ptr_wr[j]);
      e_srq[j] = (wrd[j] >= 0);
      e_swq[j] = (wwr[j] >= 0);
    end
    for (int m = 0; m < NM; m++) begin
      e_rg[m] = rstn && m_rd_req[m] && (srd[m] < 0 || (wrd[srd[m]] == m && s_rd_gnt[srd[m]]));
      e_wg[m] = rstn && m_wr_req[m] && (swr[m] < 0 || (wwr[swr[m]] == m && s_wr_gnt[swr[m]]));
    end
    chk("m_rd_gnt", 32'(m_rd_gnt), 32'(e_rg));
    chk("m_wr_gnt", 32'(m_wr_gnt), 32'(e_wg));
    for (int m = 0; m < NM; m++)
      chk($sformatf("m_rd_data[%0d]", m), m_rd_data[m], (rstn && exp_rv[m]) ? exp_rdata[m] : 32'h0);
    if (rstn) begin
      chk("s_rd_req", 32'(s_rd_req), 32'(e_srq));
      chk("s_wr_req", 32'(s_wr_req), 32'(e_swq));
      for (int j = 0; j < NS; j++) begin
        ea = 32'h0; ewa = 32'h0; ewd = 32'h0; ebe = 4'h0;
        if (wrd[j] >= 0) ea = m_rd_addr[wrd[j]];
        if (wwr[j] >= 0) begin
          ewa = m_wr_addr[wwr[j]]; ewd = m_wr_data[wwr[j]]; ebe = m_wr_be[wwr[j]];
        end
        chk($sformatf("s_rd_addr[%0d]", j), s_rd_addr[j], ea);
        chk($sformatf("s_wr_addr[%0d]", j), s_wr_addr[j], ewa);
        chk($sformatf("s_wr_data[%0d]", j), s_wr_data[j], ewd);
        chk($sformatf("s_wr_be[%0d]", j), 32'(s_wr_be[j]), 32'(ebe));
      end
    end
    // advance the reference state to what the next cycle should show
    for (int m = 0; m < NM; m++) begin
      nv[m] = e_rg[m];
      nd[m] = 32'h0;
      if (srd[m] >= 0) nd[m] = rmem[srd[m]][m_rd_addr[m][9:2]];
    end
    for (int m = 0; m < NM; m++)
      if (e_wg[m] && swr[m] >= 0)
        for (int b = 0; b < 4; b++)
          if (m_wr_be[m][b]) rmem[swr[m]][m_wr_addr[m][9:2]][8*b +: 8] = m_wr_data[m][8*b +: 8];
`ifdef NAIVE_ROUTER_RR_EN
    for (int j = 0; j < NS; j++) begin
      if (rstn && wrd[j] >= 0 && s_rd_gnt[j]) ptr_rd[j] = (wrd[j] + 1) % NM;
      if (rstn && wwr[j] >= 0 && s_wr_gnt[j]) ptr_wr[j] = (wwr[j] + 1) % NM;
    end
`endif
    if (!rstn) begin
      nv = '0;
      for (int j = 0; j < NS; j++) begin
        ptr_rd[j] = 0;
        ptr_wr[j] = 0;
        for (int i = 0; i < 256; i++) rmem[j][i] = pat(j, i);
      end
    end
    exp_rv      = nv;
    exp_rdata   = nd;
    last_rd_gnt = e_rg;
    last_wr_gnt = e_wg;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_rd_req = '0;
    m_wr_req = '0;
    for (int m = 0; m < NM; m++) begin
      m_rd_addr[m] = 32'h0; m_wr_addr[m] = 32'h0; m_wr_data[m] = 32'h0; m_wr_be[m] = 4'h0;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_rv  = '0;
    for (int j = 0; j < NS; j++) begin ptr_rd[j] = 0; ptr_wr[j] = 0; end
    rstn = 1'b0;
    idle();
    s_rd_gnt = '1;
    s_wr_gnt = '1;
    cyc();
    cyc();
    rstn = 1'b1;
    cyc();

    // two readers contend for slave 0
    m_rd_req = 2'b11; m_rd_addr[0] = 32'h10; m_rd_addr[1] = 32'h20;
    cyc();
    m_rd_req = 2'b10;
    cyc();
    idle();
    cyc();

    // simultaneous write and read by different masters
    m_wr_req = 2'b01; m_wr_addr[0] = 32'h40; m_wr_data[0] = 32'hA5A5_0000; m_wr_be[0] = 4'b1100;
    m_rd_req = 2'b10; m_rd_addr[1] = 32'h0;
    cyc();
    idle();
    m_rd_req = 2'b01; m_rd_addr[0] = 32'h40;
    cyc();
    idle();
    cyc();

    // unmapped read
    m_rd_req = 2'b10; m_rd_addr[1] = 32'h0001_0000;
    cyc();
    idle();
    cyc();

    // slave stalls for three cycles
    m_rd_req = 2'b01; m_rd_addr[0] = 32'h0002_0008; s_rd_gnt = 2'b00;
    repeat (3) cyc();
    s_rd_gnt = 2'b11;
    cyc();
    idle();
    cyc();

    // reset right after a grant drops the pending response
    m_rd_req = 2'b01; m_rd_addr[0] = 32'h4;
    cyc();
    rstn = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
    idle();
    cyc();
    m_rd_req = 2'b01;
    cyc();
    idle();
    cyc();

    // random traffic; an ungranted master holds its request
    repeat (600) begin
      for (int m = 0; m < NM; m++) begin
        if (!(m_rd_req[m] && !last_rd_gnt[m])) begin
          m_rd_req[m]  = 1'($urandom_range(0, 1));
          m_rd_addr[m] = rand_addr();
        end
        if (!(m_wr_req[m] && !last_wr_gnt[m])) begin
          m_wr_req[m]  = 1'($urandom_range(0, 1));
          m_wr_addr[m] = rand_addr();
          m_wr_data[m] = $urandom();
          m_wr_be[m]   = 4'($urandom_range(0, 15));
        end
      end
      for (int j = 0; j < NS; j++) begin
        s_rd_gnt[j] = ($urandom_range(0, 3) != 0);
        s_wr_gnt[j] = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
